ball_ctl: RTL and testbench
===========================

Name: ball_ctl

Overview:
- Frame-rate ball motion controller for PONG. It generates the 12-bit xpos/ypos that vga_draw_ball consumes, and it also produces the serve and score protocol.
- Updates once per frame on the vsync rising edge. Bounces the ball off the top and bottom walls and off the left and right paddles.
- Flags a point when a paddle misses, holds the ball during a scored pause, then recentres it.

Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- BALL_SIZE, 16, ball edge length in pixels
- SPEED, 4, pixels moved per frame on each axis
- PADDLE_H, 96, paddle height in pixels
- PADDLE_L_X, 16, left paddle left edge x
- PADDLE_W, 8, paddle width in pixels
- PADDLE_R_X, 776, right paddle left edge x
- HOLD_FRAMES, 60, frames to pause after a point

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vsync_in  in  1  vertical sync from the timing chain; its rising edge is the frame tick
- serve  in  1  single-cycle serve request
- serve_dir  in  1  serve direction: 1 = right, 0 = left
- paddle_l_y  in  12  top y of the left paddle
- paddle_r_y  in  12  top y of the right paddle
- xpos  out  12  ball top-left x (registered)
- ypos  out  12  ball top-left y (registered)
- point_l  out  1  one-cycle pulse: left player scored
- point_r  out  1  one-cycle pulse: right player scored
- in_play  out  1  high while the FSM is in MOVE

Behaviour:
- Local constants:
  - CX = (SCREEN_W-BALL_SIZE)/2 = 392
  - CY = (SCREEN_H-BALL_SIZE)/2 = 292
  - YMAX = SCREEN_H-BALL_SIZE = 584
  - XMAX = SCREEN_W-BALL_SIZE = 784
  - FACE_L = PADDLE_L_X+PADDLE_W = 24
  - FACE_R = PADDLE_R_X-BALL_SIZE = 760
- Reset values:
  - xpos=CX, ypos=CY, dir_x=right, dir_y=down
  - state=IDLE, point_l=point_r=0, in_play=0
  - hold counter=0, vsync_d=0
- Frame tick: tick = vsync_in & ~vsync_d, with vsync_d registered every cycle. All motion happens on the pclk edge where tick=1; new xpos/ypos are visible from the following cycle. Paddle inputs are sampled on that same edge.
- FSM state IDLE:
  - Ball held at CX/CY.
  - serve=1 -> MOVE, dir_x=serve_dir, dir_y unchanged.
  - Movement begins on the next tick, even if serve coincides with a tick.
- FSM state MOVE:
  - On each tick, the Y and X rules below are evaluated in parallel from pre-tick values.
  - serve is ignored.
- Y rule:
  - Moving down: if ypos+SPEED >= YMAX then ypos=YMAX, dir_y=up; else ypos += SPEED.
  - Moving up: if ypos <= SPEED then ypos=0, dir_y=down; else ypos -= SPEED.
- X rule, moving right:
  - Hit: xpos <= FACE_R, xpos+SPEED >= FACE_R, and ypos+BALL_SIZE > paddle_r_y and ypos < paddle_r_y+PADDLE_H -> xpos=FACE_R, dir_x=left.
  - Miss: else if xpos+SPEED >= XMAX -> point_l pulse, state SCORED, xpos=XMAX.
  - Otherwise xpos += SPEED.
- X rule, moving left (mirror of the right case):
  - Hit: xpos >= FACE_L, xpos-SPEED <= FACE_L, with vertical overlap against paddle_l_y -> xpos=FACE_L, dir_x=right.
  - Miss: else if xpos <= SPEED -> point_r pulse, state SCORED, xpos=0.
  - Otherwise xpos -= SPEED.
- Corner priority: a wall bounce and a paddle hit or miss on the same tick are both applied.
- Past the face: once the ball is beyond the paddle face it can no longer be hit and always reaches the miss.
- FSM state SCORED:
  - Ball frozen; the counter increments per tick.
  - When count = HOLD_FRAMES-1 on a tick -> IDLE; xpos=CX, ypos=CY, counter cleared.
  - serve is ignored.
- Arithmetic is unsigned, 12-bit, with compares done on 13-bit extended sums. No wrap-around can occur.
- point_l/point_r are high for exactly one pclk cycle, never together.
- rst asserted in any state restores all reset values on the next edge.

Decomposition:
- pong_pkg holds:
  - screen and paddle geometry constants (SCREEN_W/H, BALL_SIZE, PADDLE_*)
  - the FSM state encoding (IDLE, MOVE, SCORED)
  - the direction encodings
- One sub-module, edge_tick: registered rising-edge detector on vsync_in (pclk, rst) that outputs tick.
- ball_ctl instantiates edge_tick and holds the FSM, the motion datapath and the hold counter.

Test Plan:
1. Apply rst, then 10 vsync edges with no serve -> xpos=392, ypos=292, in_play=0 throughout.
2. serve=1 with serve_dir=1, then 1 tick -> xpos=396, ypos=296, in_play=1. serve pulsed again mid-MOVE -> no effect.
3. Ball at ypos=582 moving down, then 2 ticks -> ypos=584 then 580, dir_y flips to up. Ball at ypos=3 moving up -> ypos=0, next tick 4.
4. paddle_r_y=250, ball xpos=758, ypos=292, moving right, 1 tick -> xpos=760, dir_x=left; next tick -> xpos=756; no point pulse.
5. paddle_r_y=0, ball xpos=758 moving right, then ticks -> ball passes 760, reaches 782, next tick point_l pulses for 1 cycle and xpos=784. Stays frozen for 60 ticks, then IDLE at 392/292. Left-side mirror produces point_r.
6. rst asserted while in MOVE at xpos=500 -> next cycle xpos=392, ypos=292, state IDLE, no point pulse.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - PONG geometry constants, FSM/direction encodings and a paddle overlap helper
package pong_pkg;

  localparam int SCREEN_W    = 800;
  localparam int SCREEN_H    = 600;
  localparam int BALL_SIZE   = 16;
  localparam int SPEED       = 4;
  localparam int PADDLE_H    = 96;
  localparam int PADDLE_L_X  = 16;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_R_X  = 776;
  localparam int HOLD_FRAMES = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_x_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_y_t;

  // Ball rows [y, y+ball) intersect paddle rows [p, p+ph); 13-bit sums cannot wrap.
  function automatic logic overlap(input logic [11:0] y, input logic [11:0] p,
                                   input logic [12:0] ball, input logic [12:0] ph);
    return (({1'b0, y} + ball) > {1'b0, p}) && ({1'b0, y} < ({1'b0, p} + ph));
  endfunction

endpackage

// File: rtl/edge_tick.sv
// rtl/edge_tick.sv - rising-edge detector producing the per-frame tick from vsync
module edge_tick (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic tick
);

  logic sig_d;

  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign tick = sig & ~sig_d;

endmodule

// File: rtl/ball_ctl.sv
// rtl/ball_ctl.sv - frame-rate PONG ball motion, paddle bounce, scoring and serve FSM
module ball_ctl
  import pong_pkg::*;
#(
  parameter int SCREEN_W_P    = SCREEN_W,
  parameter int SCREEN_H_P    = SCREEN_H,
  parameter int BALL_SIZE_P   = BALL_SIZE,
  parameter int SPEED_P       = SPEED,
  parameter int PADDLE_H_P    = PADDLE_H,
  parameter int PADDLE_L_X_P  = PADDLE_L_X,
  parameter int PADDLE_W_P    = PADDLE_W,
  parameter int PADDLE_R_X_P  = PADDLE_R_X,
  parameter int HOLD_FRAMES_P = HOLD_FRAMES
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        serve,
  input  logic        serve_dir,
  input  logic [11:0] paddle_l_y,
  input  logic [11:0] paddle_r_y,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        point_l,
  output logic        point_r,
  output logic        in_play
);

  localparam logic [12:0] CX     = 13'((SCREEN_W_P - BALL_SIZE_P) / 2);
  localparam logic [12:0] CY     = 13'((SCREEN_H_P - BALL_SIZE_P) / 2);
  localparam logic [12:0] YMAX   = 13'(SCREEN_H_P - BALL_SIZE_P);
  localparam logic [12:0] XMAX   = 13'(SCREEN_W_P - BALL_SIZE_P);
  localparam logic [12:0] FACE_L = 13'(PADDLE_L_X_P + PADDLE_W_P);
  localparam logic [12:0] FACE_R = 13'(PADDLE_R_X_P - BALL_SIZE_P);
  localparam logic [12:0] SPD    = 13'(SPEED_P);
  localparam logic [12:0] BSZ    = 13'(BALL_SIZE_P);
  localparam logic [12:0] PH     = 13'(PADDLE_H_P);
  localparam int          CW     = (HOLD_FRAMES_P > 2) ? $clog2(HOLD_FRAMES_P) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES_P - 1);

  logic          tick;
  state_t        state;
  dir_x_t        dir_x;
  dir_y_t        dir_y;
  logic [CW-1:0] hold_cnt;

  logic [12:0] x13, y13;
  logic [11:0] x_nxt, y_nxt;
  dir_x_t      dx_nxt;
  dir_y_t      dy_nxt;
  logic        score_l, score_r;

  edge_tick u_edge_tick (
    .clk (pclk),
    .rst (rst),
    .sig (vsync_in),
    .tick(tick)
  );

  assign x13 = {1'b0, xpos};
  assign y13 = {1'b0, ypos};

  // Next-frame motion from pre-tick values; Y and X resolve independently so corners apply both.
  always_comb begin
    y_nxt   = ypos;
    dy_nxt  = dir_y;
    x_nxt   = xpos;
    dx_nxt  = dir_x;
    score_l = 1'b0;
    score_r = 1'b0;

    if (dir_y == DIR_DOWN) begin
      if (y13 + SPD >= YMAX) begin
        y_nxt  = YMAX[11:0];
        dy_nxt = DIR_UP;
      end else begin
        y_nxt = 12'(y13 + SPD);
      end
    end else begin
      if (y13 <= SPD) begin
        y_nxt  = 12'd0;
        dy_nxt = DIR_DOWN;
      end else begin
        y_nxt = 12'(y13 - SPD);
      end
    end

    if (dir_x == DIR_RIGHT) begin
      if (x13 <= FACE_R && x13 + SPD >= FACE_R && overlap(ypos, paddle_r_y, BSZ, PH)) begin
        x_nxt  = FACE_R[11:0];
        dx_nxt = DIR_LEFT;
      end else if (x13 + SPD >= XMAX) begin
        x_nxt   = XMAX[11:0];
        score_l = 1'b1;
      end else begin
        x_nxt = 12'(x13 + SPD);
      end
    end else begin
      if (x13 >= FACE_L && x13 <= FACE_L + SPD && overlap(ypos, paddle_l_y, BSZ, PH)) begin
        x_nxt  = FACE_L[11:0];
        dx_nxt = DIR_RIGHT;
      end else if (x13 <= SPD) begin
        x_nxt   = 12'd0;
        score_r = 1'b1;
      end else begin
        x_nxt = 12'(x13 - SPD);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      xpos     <= CX[11:0];
      ypos     <= CY[11:0];
      dir_x    <= DIR_RIGHT;
      dir_y    <= DIR_DOWN;
      hold_cnt <= '0;
      point_l  <= 1'b0;
      point_r  <= 1'b0;
      in_play  <= 1'b0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        IDLE: begin
          xpos <= CX[11:0];
          ypos <= CY[11:0];
          if (serve) begin
            state   <= MOVE;
            dir_x   <= dir_x_t'(serve_dir);
            in_play <= 1'b1;
          end
        end
        MOVE: begin
          if (tick) begin
            xpos  <= x_nxt;
            ypos  <= y_nxt;
            dir_x <= dx_nxt;
            dir_y <= dy_nxt;
            if (score_l || score_r) begin
              state   <= SCORED;
              in_play <= 1'b0;
              point_l <= score_l;
              point_r <= score_r;
            end
          end
        end
        SCORED: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= IDLE;
              xpos     <= CX[11:0];
              ypos     <= CY[11:0];
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          in_play <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_ctl.sv
// tb/tb_ball_ctl.sv - self-checking bench for ball_ctl with a per-tick expected-value scoreboard
module tb_ball_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_in = 1'b0;
  logic        serve = 1'b0;
  logic        serve_dir = 1'b0;
  logic [11:0] paddle_l_y = 12'd0;
  logic [11:0] paddle_r_y = 12'd0;
  logic [11:0] xpos, ypos;
  logic        point_l, point_r, in_play;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int x;
    int y;
    bit pl;
    bit pr;
    bit ip;
  } exp_t;

  exp_t sb[$];

  // Reference game state: st 0=IDLE 1=MOVE 2=SCORED, dx 1=right, dy 1=down
  int m_x, m_y, m_dx, m_dy, m_st, m_cnt;
  bit track_mode;
  bit last_pl, last_pr;

  ball_ctl dut (
    .pclk      (pclk),
    .rst       (rst),
    .vsync_in  (vsync_in),
    .serve     (serve),
    .serve_dir (serve_dir),
    .paddle_l_y(paddle_l_y),
    .paddle_r_y(paddle_r_y),
    .xpos      (xpos),
    .ypos      (ypos),
    .point_l   (point_l),
    .point_r   (point_r),
    .in_play   (in_play)
  );

  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_x = 392; m_y = 292; m_dx = 1; m_dy = 1; m_st = 0; m_cnt = 0;
    sb.delete();
  endtask

  // Paddles either follow the ball (guaranteed overlap) or sit far away from it.
  task automatic set_paddles();
    int p;
    if (track_mode) p = (m_y >= 40) ? m_y - 40 : 0;
    else            p = (m_y >= 200) ? 0 : 400;
    paddle_l_y = 12'(p);
    paddle_r_y = 12'(p);
  endtask

  task automatic model_tick(input bit srv, input bit sdir);
    int nx, ny, ndx, ndy, nst, pl_i, pr_i;
    exp_t e;
    nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; nst = m_st;
    pl_i = paddle_l_y; pr_i = paddle_r_y;
    e.pl = 0; e.pr = 0;
    if (m_st == 1) begin
      if (m_dy == 1) begin
        if (m_y + 4 >= 584) begin ny = 584; ndy = 0; end else ny = m_y + 4;
      end else begin
        if (m_y <= 4) begin ny = 0; ndy = 1; end else ny = m_y - 4;
      end
      if (m_dx == 1) begin
        if (m_x <= 760 && m_x + 4 >= 760 && m_y + 16 > pr_i && m_y < pr_i + 96) begin
          nx = 760; ndx = 0;
        end else if (m_x + 4 >= 784) begin
          nx = 784; nst = 2; e.pl = 1;
        end else nx = m_x + 4;
      end else begin
        if (m_x >= 24 && m_x - 4 <= 24 && m_y + 16 > pl_i && m_y < pl_i + 96) begin
          nx = 24; ndx = 1;
        end else if (m_x <= 4) begin
          nx = 0; nst = 2; e.pr = 1;
        end else nx = m_x - 4;
      end
    end else if (m_st == 2) begin
      if (m_cnt == 59) begin
        nst = 0; nx = 392; ny = 292; m_cnt = 0;
      end else m_cnt = m_cnt + 1;
    end else if (srv) begin
      nst = 1; ndx = sdir;
    end
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_st = nst;
    e.x = nx; e.y = ny; e.ip = (nst == 1);
    sb.push_back(e);
  endtask

  // One frame: vsync high for two cycles (only the first edge may tick), then low.
  task automatic do_tick(input bit srv, input bit sdir);
    exp_t e;
    @(negedge pclk);
    set_paddles();
    vsync_in = 1'b1;
    serve = srv;
    serve_dir = sdir;
    model_tick(srv, sdir);
    @(posedge pclk); #1;
    e = sb.pop_front();
    last_pl = point_l;
    last_pr = point_r;
    tests_run++;
    if (xpos !== 12'(e.x) || ypos !== 12'(e.y) || point_l !== e.pl || point_r !== e.pr || in_play !== e.ip) begin
      tests_failed++;
      $display("FAIL frame: got x=%0d y=%0d pl=%b pr=%b ip=%b, required x=%0d y=%0d pl=%b pr=%b ip=%b",
               xpos, ypos, point_l, point_r, in_play, e.x, e.y, e.pl, e.pr, e.ip);
    end
    @(negedge pclk);
    serve = 1'b0;
    @(posedge pclk); #1;
    tests_run++;
    if (point_l !== 1'b0 || point_r !== 1'b0 || xpos !== 12'(e.x)) begin
      tests_failed++;
      $display("FAIL pulse_width: got pl=%b pr=%b x=%0d one cycle after tick, required pl=0 pr=0 x=%0d",
               point_l, point_r, xpos, e.x);
    end
    @(negedge pclk);
    vsync_in = 1'b0;
    repeat (2) @(posedge pclk);
  endtask

  task automatic do_serve(input bit sdir);
    @(negedge pclk);
    serve = 1'b1;
    serve_dir = sdir;
    @(posedge pclk); #1;
    if (m_st == 0) begin m_st = 1; m_dx = sdir; end
    tests_run++;
    if (in_play !== (m_st == 1)) begin
      tests_failed++;
      $display("FAIL serve_in_play: got %b, required %b", in_play, (m_st == 1));
    end
    @(negedge pclk);
    serve = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    model_reset();
    tests_run++;
    if (xpos !== 12'd392 || ypos !== 12'd292 || in_play !== 1'b0 || point_l !== 1'b0 || point_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got x=%0d y=%0d ip=%b pl=%b pr=%b, required 392 292 0 0 0",
               xpos, ypos, in_play, point_l, point_r);
    end
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b0);
    tests_run++;
    if (xpos !== 12'd392 || ypos !== 12'd292 || in_play !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: got x=%0d y=%0d ip=%b, required 392 292 0", xpos, ypos, in_play);
    end
  endtask

  task automatic test_serve();
    track_mode = 1'b1;
    do_tick(1'b1, 1'b1);
    tests_run++;
    if (xpos !== 12'd392 || in_play !== 1'b1) begin
      tests_failed++;
      $display("FAIL serve_on_tick: got x=%0d ip=%b, required 392 1", xpos, in_play);
    end
    do_tick(1'b0, 1'b0);
    tests_run++;
    if (xpos !== 12'd396 || ypos !== 12'd296) begin
      tests_failed++;
      $display("FAIL first_move: got x=%0d y=%0d, required 396 296", xpos, ypos);
    end
    do_serve(1'b0);
    do_tick(1'b0, 1'b0);
    tests_run++;
    if (xpos !== 12'd400 || ypos !== 12'd300) begin
      tests_failed++;
      $display("FAIL serve_ignored: got x=%0d y=%0d, required 400 300", xpos, ypos);
    end
  endtask

  task automatic test_wall();
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      do_tick(1'b0, 1'b0);
      if (ypos === 12'd584) hit = 1;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL wall_reach: got y=%0d after 100 ticks, required 584", ypos);
    end
    do_tick(1'b0, 1'b0);
    tests_run++;
    if (ypos !== 12'd580) begin
      tests_failed++;
      $display("FAIL wall_bounce: got y=%0d, required 580", ypos);
    end
  endtask

  task automatic test_paddle_hit();
    bit hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      do_tick(1'b0, 1'b0);
      if (xpos === 12'd760) hit = 1;
    end
    tests_run++;
    if (!hit || last_pl !== 1'b0) begin
      tests_failed++;
      $display("FAIL paddle_r_hit: got x=%0d pl=%b, required 760 0", xpos, last_pl);
    end
    do_tick(1'b0, 1'b0);
    tests_run++;
    if (xpos !== 12'd756) begin
      tests_failed++;
      $display("FAIL paddle_r_rebound: got x=%0d, required 756", xpos);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 59; i++) do_tick(1'b0, 1'b0);
    tests_run++;
    if (in_play !== 1'b0 || !(xpos === 12'd0 || xpos === 12'd784)) begin
      tests_failed++;
      $display("FAIL hold_frozen: got x=%0d ip=%b, required 0 or 784 and ip 0", xpos, in_play);
    end
    do_tick(1'b0, 1'b0);
    tests_run++;
    if (xpos !== 12'd392 || ypos !== 12'd292 || in_play !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_recentre: got x=%0d y=%0d ip=%b, required 392 292 0", xpos, ypos, in_play);
    end
  endtask

  task automatic test_miss_left();
    bit scored = 0;
    track_mode = 1'b0;
    for (int i = 0; i < 300 && !scored; i++) begin
      do_tick(1'b0, 1'b0);
      if (last_pr === 1'b1) scored = 1;
    end
    tests_run++;
    if (!scored || xpos !== 12'd0) begin
      tests_failed++;
      $display("FAIL miss_left: got scored=%b x=%0d, required 1 0", scored, xpos);
    end
    test_hold();
  endtask

  task automatic test_miss_right();
    bit scored = 0;
    bit past = 0;
    track_mode = 1'b0;
    do_serve(1'b1);
    for (int i = 0; i < 200 && !scored; i++) begin
      do_tick(1'b0, 1'b0);
      if (xpos > 12'd760 && xpos < 12'd784) past = 1;
      if (last_pl === 1'b1) scored = 1;
    end
    tests_run++;
    if (!scored || !past || xpos !== 12'd784) begin
      tests_failed++;
      $display("FAIL miss_right: got scored=%b past_face=%b x=%0d, required 1 1 784", scored, past, xpos);
    end
    test_hold();
  endtask

  task automatic test_rst_mid_move();
    bit at = 0;
    do_serve(1'b1);
    for (int i = 0; i < 60 && !at; i++) begin
      do_tick(1'b0, 1'b0);
      if (xpos === 12'd500) at = 1;
    end
    @(negedge pclk);
    rst = 1'b1;
    @(posedge pclk); #1;
    tests_run++;
    if (!at || xpos !== 12'd392 || ypos !== 12'd292 || in_play !== 1'b0 || point_l !== 1'b0 || point_r !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_move: got reached=%b x=%0d y=%0d ip=%b pl=%b pr=%b, required 1 392 292 0 0 0",
               at, xpos, ypos, in_play, point_l, point_r);
    end
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    do_tick(1'b0, 1'b0);
  endtask

  initial begin
    track_mode = 1'b1;
    model_reset();
    test_reset();
    test_idle();
    test_serve();
    test_wall();
    test_paddle_hit();
    test_miss_left();
    test_miss_right();
    test_rst_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
